cdb_arbiter: RTL and testbench

- Arbitrates the single common data bus (CDB) among the four execution units: int, ls, mult and div.
- Each cycle it selects at most one pending result and broadcasts its tag, data and branch outcome to dispatch and to all issue queues.
- Selection is round-robin, with an aging override so that a long-waiting unit cannot starve.
- Sits between the execution units and the cdb_dispatch_* / issue-queue CDB inputs.

---
 rtl/cdb_arbiter.sv | 138 +++++++++++++
 tb/tb_cdb_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one of four execution-unit results per cycle
// (starvation override first, then round-robin) and broadcasts it one cycle later.
module cdb_arbiter #(
    parameter int W_TAG        = 6,
    parameter int W_DATA       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_req,
    input  logic [W_TAG-1:0]  int_tag,
    input  logic [W_DATA-1:0] int_data,
    input  logic              int_branch,
    input  logic              int_taken,
    input  logic              ls_req,
    input  logic [W_TAG-1:0]  ls_tag,
    input  logic [W_DATA-1:0] ls_data,
    input  logic              ls_branch,
    input  logic              ls_taken,
    input  logic              mult_req,
    input  logic [W_TAG-1:0]  mult_tag,
    input  logic [W_DATA-1:0] mult_data,
    input  logic              mult_branch,
    input  logic              mult_taken,
    input  logic              div_req,
    input  logic [W_TAG-1:0]  div_tag,
    input  logic [W_DATA-1:0] div_data,
    input  logic              div_branch,
    input  logic              div_taken,
    output logic              int_grant,
    output logic              ls_grant,
    output logic              mult_grant,
    output logic              div_grant,
    output logic              cdb_valid,
    output logic [W_TAG-1:0]  cdb_tag,
    output logic [W_DATA-1:0] cdb_data,
    output logic              cdb_branch,
    output logic              cdb_branch_taken
);
    localparam logic [7:0] STARVE_LIM_C = 8'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_MAX_C   = 8'd255;

    logic [3:0]        req_s;
    logic [3:0]        grant_s;
    logic [3:0]        starved_s;
    logic [3:0]        branch_s;
    logic [3:0]        taken_s;
    logic [W_TAG-1:0]  tag_s  [4];
    logic [W_DATA-1:0] data_s [4];
    logic [1:0]        gnt_idx_s;
    logic              gnt_any_s;
    logic [1:0]        ptr_r;
    logic [7:0]        wait_r [4];

    assign req_s    = {div_req, mult_req, ls_req, int_req};
    assign branch_s = {div_branch, mult_branch, ls_branch, int_branch};
    assign taken_s  = {div_taken, mult_taken, ls_taken, int_taken};
    assign tag_s[0]  = int_tag;
    assign tag_s[1]  = ls_tag;
    assign tag_s[2]  = mult_tag;
    assign tag_s[3]  = div_tag;
    assign data_s[0] = int_data;
    assign data_s[1] = ls_data;
    assign data_s[2] = mult_data;
    assign data_s[3] = div_data;

    assign int_grant  = grant_s[0];
    assign ls_grant   = grant_s[1];
    assign mult_grant = grant_s[2];
    assign div_grant  = grant_s[3];

    // Grant selection: lowest starved requester, else first requester from the pointer
    always_comb begin
        logic [1:0] cand_v;
        cand_v    = 2'd0;
        starved_s = 4'b0000;
        grant_s   = 4'b0000;
        gnt_idx_s = 2'd0;
        gnt_any_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            starved_s[i] = req_s[i] && (wait_r[i] >= STARVE_LIM_C);
        end
        if (reset) begin
            gnt_any_s = 1'b0;
        end else if (|starved_s) begin
            // Scanning downward leaves the lowest starved index as the winner
            for (int i = 3; i >= 0; i--) begin
                gnt_idx_s = starved_s[i] ? 2'(i) : gnt_idx_s;
            end
            gnt_any_s = 1'b1;
        end else begin
            // Scanning the ring backwards leaves the requester closest to the pointer
            for (int k = 3; k >= 0; k--) begin
                cand_v    = ptr_r + 2'(k);
                gnt_idx_s = req_s[cand_v] ? cand_v : gnt_idx_s;
                gnt_any_s = gnt_any_s | req_s[cand_v];
            end
        end
        if (gnt_any_s) begin
            grant_s[gnt_idx_s] = 1'b1;
        end else begin
            grant_s = 4'b0000;
        end
    end

    // Round-robin pointer, per-unit wait counters and the registered broadcast
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r            <= 2'd0;
            cdb_valid        <= 1'b0;
            cdb_tag          <= '0;
            cdb_data         <= '0;
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                wait_r[i] <= 8'd0;
            end
        end else begin
            cdb_valid <= gnt_any_s;
            if (gnt_any_s) begin
                ptr_r            <= gnt_idx_s + 2'd1;
                cdb_tag          <= tag_s[gnt_idx_s];
                cdb_data         <= data_s[gnt_idx_s];
                cdb_branch       <= branch_s[gnt_idx_s];
                cdb_branch_taken <= branch_s[gnt_idx_s] & taken_s[gnt_idx_s];
            end else begin
                ptr_r <= ptr_r;
            end
            for (int i = 0; i < 4; i++) begin
                if (req_s[i] && !grant_s[i]) begin
                    wait_r[i] <= (wait_r[i] == WAIT_MAX_C) ? WAIT_MAX_C : wait_r[i] + 8'd1;
                end else begin
                    wait_r[i] <= 8'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: two instances (STARVE_LIMIT 8 and 2) driven by directed
// scenarios and legal random traffic, checked against a behavioural model.
module tb_cdb_arbiter;
    localparam int W_TAG  = 6;
    localparam int W_DATA = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              req  [2][4];
    logic [W_TAG-1:0]  tag  [2][4];
    logic [W_DATA-1:0] data [2][4];
    logic              br   [2][4];
    logic              tk   [2][4];
    logic              gnt  [2][4];
    logic              cv   [2];
    logic [W_TAG-1:0]  ct   [2];
    logic [W_DATA-1:0] cd   [2];
    logic              cb   [2];
    logic              ctk  [2];

    int checks = 0;
    int errors = 0;
    int lim [2] = '{8, 2};

    // Reference model state
    int                m_ptr  [2];
    int                m_wait [2][4];
    logic              m_cv   [2];
    logic [W_TAG-1:0]  m_ct   [2];
    logic [W_DATA-1:0] m_cd   [2];
    logic              m_cb   [2];
    logic              m_ctk  [2];
    int                last_g [2];

    cdb_arbiter #(.W_TAG(W_TAG), .W_DATA(W_DATA), .STARVE_LIMIT(8)) dut0 (
        .clk(clk), .reset(reset),
        .int_req(req[0][0]), .int_tag(tag[0][0]), .int_data(data[0][0]), .int_branch(br[0][0]), .int_taken(tk[0][0]),
        .ls_req(req[0][1]), .ls_tag(tag[0][1]), .ls_data(data[0][1]), .ls_branch(br[0][1]), .ls_taken(tk[0][1]),
        .mult_req(req[0][2]), .mult_tag(tag[0][2]), .mult_data(data[0][2]), .mult_branch(br[0][2]), .mult_taken(tk[0][2]),
        .div_req(req[0][3]), .div_tag(tag[0][3]), .div_data(data[0][3]), .div_branch(br[0][3]), .div_taken(tk[0][3]),
        .int_grant(gnt[0][0]), .ls_grant(gnt[0][1]), .mult_grant(gnt[0][2]), .div_grant(gnt[0][3]),
        .cdb_valid(cv[0]), .cdb_tag(ct[0]), .cdb_data(cd[0]), .cdb_branch(cb[0]), .cdb_branch_taken(ctk[0])
    );

    cdb_arbiter #(.W_TAG(W_TAG), .W_DATA(W_DATA), .STARVE_LIMIT(2)) dut1 (
        .clk(clk), .reset(reset),
        .int_req(req[1][0]), .int_tag(tag[1][0]), .int_data(data[1][0]), .int_branch(br[1][0]), .int_taken(tk[1][0]),
        .ls_req(req[1][1]), .ls_tag(tag[1][1]), .ls_data(data[1][1]), .ls_branch(br[1][1]), .ls_taken(tk[1][1]),
        .mult_req(req[1][2]), .mult_tag(tag[1][2]), .mult_data(data[1][2]), .mult_branch(br[1][2]), .mult_taken(tk[1][2]),
        .div_req(req[1][3]), .div_tag(tag[1][3]), .div_data(data[1][3]), .div_branch(br[1][3]), .div_taken(tk[1][3]),
        .int_grant(gnt[1][0]), .ls_grant(gnt[1][1]), .mult_grant(gnt[1][2]), .div_grant(gnt[1][3]),
        .cdb_valid(cv[1]), .cdb_tag(ct[1]), .cdb_data(cd[1]), .cdb_branch(cb[1]), .cdb_branch_taken(ctk[1])
    );

    function automatic logic [3:0] gvec(int d);
        return {gnt[d][3], gnt[d][2], gnt[d][1], gnt[d][0]};
    endfunction

    function automatic logic [3:0] onehot(int g);
        logic [3:0] v;
        v = 4'b0000;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Winner by the arbitration rules: starved (lowest index) first, then ring order
    function automatic int model_grant(int d);
        if (reset) return -1;
        for (int i = 0; i < 4; i++)
            if (req[d][i] && m_wait[d][i] >= lim[d]) return i;
        for (int k = 0; k < 4; k++)
            if (req[d][(m_ptr[d] + k) % 4]) return (m_ptr[d] + k) % 4;
        return -1;
    endfunction

    task automatic tick();
        int g [2];
        for (int d = 0; d < 2; d++) g[d] = model_grant(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            last_g[d] = g[d];
            if (reset) begin
                m_ptr[d] = 0; m_cv[d] = 1'b0; m_ct[d] = '0; m_cd[d] = '0; m_cb[d] = 1'b0; m_ctk[d] = 1'b0;
                for (int i = 0; i < 4; i++) m_wait[d][i] = 0;
            end else begin
                m_cv[d] = (g[d] >= 0);
                if (g[d] >= 0) begin
                    m_ct[d]  = tag[d][g[d]];
                    m_cd[d]  = data[d][g[d]];
                    m_cb[d]  = br[d][g[d]];
                    m_ctk[d] = br[d][g[d]] & tk[d][g[d]];
                    m_ptr[d] = (g[d] + 1) % 4;
                end
                for (int i = 0; i < 4; i++)
                    m_wait[d][i] = (req[d][i] && i != g[d]) ? ((m_wait[d][i] < 255) ? m_wait[d][i] + 1 : 255) : 0;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++)
            for (int u = 0; u < 4; u++) begin
                req[d][u] = 1'b0; tag[d][u] = '0; data[d][u] = '0; br[d][u] = 1'b0; tk[d][u] = 1'b0;
            end
    endtask

    task automatic set_req(int d, int u, int t, logic [W_DATA-1:0] dv, logic b, logic k);
        req[d][u] = 1'b1; tag[d][u] = W_TAG'(t); data[d][u] = dv; br[d][u] = b; tk[d][u] = k;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) for (int u = 0; u < 4; u++) req[d][u] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (gvec(d) !== 4'b0000) begin errors++; $display("FAIL reset_grant dut%0d: got %b expected 0000", d, gvec(d)); end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({cv[d], ct[d], cd[d], cb[d], ctk[d]} !== '0)
                begin errors++; $display("FAIL reset_cdb dut%0d: valid %b tag %h data %h br %b tk %b expected all 0", d, cv[d], ct[d], cd[d], cb[d], ctk[d]); end
        end
        reset = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 0, 5, 32'h0000_1234, 1'b0, 1'b0);
        #1;
        checks++;
        if (gvec(0) !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", gvec(0)); end
        tick();
        req[0][0] = 1'b0;
        checks++;
        if (cv[0] !== 1'b1 || ct[0] !== 6'd5 || cd[0] !== 32'h0000_1234)
            begin errors++; $display("FAIL single_cdb: valid %b tag %0d data %h expected 1 5 00001234", cv[0], ct[0], cd[0]); end
        set_req(0, 0, 6, 32'h0, 1'b0, 1'b0);
        set_req(0, 1, 7, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (gvec(0) !== 4'b0010) begin errors++; $display("FAIL single_ptr: got %b expected 0010", gvec(0)); end
        tick();
        clear_inputs();
    endtask

    task automatic test_rotation();
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int u = 0; u < 4; u++) set_req(0, u, 10 + u, 32'(u), 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (gvec(0) !== onehot(exp_idx[c])) begin errors++; $display("FAIL rotate_grant c%0d: got %b expected %b", c, gvec(0), onehot(exp_idx[c])); end
            tick();
            checks++;
            if (cv[0] !== 1'b1 || ct[0] !== 6'(10 + exp_idx[c]))
                begin errors++; $display("FAIL rotate_tag c%0d: valid %b tag %0d expected 1 %0d", c, cv[0], ct[0], 10 + exp_idx[c]); end
        end
        clear_inputs();
    endtask

    task automatic test_starve();
        int exp_idx [2][4] = '{'{0, 1, 2, 3}, '{0, 1, 3, 0}};
        for (int d = 0; d < 2; d++) begin
            do_reset();
            set_req(d, 0, 20, 32'h20, 1'b0, 1'b0);
            set_req(d, 1, 21, 32'h21, 1'b0, 1'b0);
            set_req(d, 3, 23, 32'h23, 1'b0, 1'b0);
            for (int c = 0; c < 4; c++) begin
                if (c == 2) set_req(d, 2, 22, 32'h22, 1'b0, 1'b0);
                #1;
                checks++;
                if (gvec(d) !== onehot(exp_idx[d][c])) begin errors++; $display("FAIL starve_grant dut%0d c%0d: got %b expected %b", d, c, gvec(d), onehot(exp_idx[d][c])); end
                tick();
                checks++;
                if (ct[d] !== 6'(20 + exp_idx[d][c])) begin errors++; $display("FAIL starve_tag dut%0d c%0d: got %0d expected %0d", d, c, ct[d], 20 + exp_idx[d][c]); end
                if (exp_idx[d][c] >= 2) req[d][exp_idx[d][c]] = 1'b0;
            end
            clear_inputs();
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_req(0, 1, 3, 32'h3, 1'b1, 1'b1);
        #1;
        checks++;
        if (gvec(0) !== 4'b0010) begin errors++; $display("FAIL branch_grant_ls: got %b expected 0010", gvec(0)); end
        tick();
        req[0][1] = 1'b0;
        checks++;
        if ({cv[0], cb[0], ctk[0]} !== 3'b111) begin errors++; $display("FAIL branch_taken: got %b expected 111", {cv[0], cb[0], ctk[0]}); end
        set_req(0, 2, 4, 32'h4, 1'b0, 1'b1);
        #1;
        checks++;
        if (gvec(0) !== 4'b0100) begin errors++; $display("FAIL branch_grant_mult: got %b expected 0100", gvec(0)); end
        tick();
        req[0][2] = 1'b0;
        checks++;
        if ({cv[0], cb[0], ctk[0]} !== 3'b100) begin errors++; $display("FAIL nonbranch_taken: got %b expected 100", {cv[0], cb[0], ctk[0]}); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 2, 12, 32'hC, 1'b0, 1'b0);
        #1;
        checks++;
        if (gvec(0) !== 4'b0100) begin errors++; $display("FAIL midrst_mult: got %b expected 0100", gvec(0)); end
        tick();
        reset = 1'b1;
        for (int u = 0; u < 4; u++) set_req(0, u, u, 32'(u), 1'b0, 1'b0);
        #1;
        checks++;
        if (gvec(0) !== 4'b0000 || cv[0] !== 1'b1) begin errors++; $display("FAIL midrst_hold: grant %b valid %b expected 0000 1", gvec(0), cv[0]); end
        tick();
        reset = 1'b0;
        checks++;
        if (cv[0] !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", cv[0]); end
        #1;
        checks++;
        if (gvec(0) !== 4'b0001) begin errors++; $display("FAIL midrst_restart: got %b expected 0001", gvec(0)); end
        tick();
        clear_inputs();
    endtask

    task automatic test_idle();
        do_reset();
        set_req(0, 0, 9, 32'h99, 1'b0, 1'b0);
        tick();
        req[0][0] = 1'b0;
        checks++;
        if (cv[0] !== 1'b1 || ct[0] !== 6'd9) begin errors++; $display("FAIL idle_first: valid %b tag %0d expected 1 9", cv[0], ct[0]); end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (gvec(0) !== 4'b0000) begin errors++; $display("FAIL idle_grant c%0d: got %b expected 0000", c, gvec(0)); end
            tick();
            checks++;
            if (cv[0] !== 1'b0 || ct[0] !== 6'd9) begin errors++; $display("FAIL idle_hold c%0d: valid %b tag %0d expected 0 9", c, cv[0], ct[0]); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (gvec(d) !== onehot(model_grant(d)))
                    begin errors++; $display("FAIL rand_grant dut%0d c%0d: got %b expected %b", d, c, gvec(d), onehot(model_grant(d))); end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({cv[d], ct[d], cd[d], cb[d], ctk[d]} !== {m_cv[d], m_ct[d], m_cd[d], m_cb[d], m_ctk[d]})
                    begin errors++; $display("FAIL rand_cdb dut%0d c%0d: got %b/%h/%h/%b/%b expected %b/%h/%h/%b/%b", d, c,
                        cv[d], ct[d], cd[d], cb[d], ctk[d], m_cv[d], m_ct[d], m_cd[d], m_cb[d], m_ctk[d]); end
            end
            // Legal traffic: hold until granted, occasionally abandon, sometimes start new
            for (int d = 0; d < 2; d++)
                for (int u = 0; u < 4; u++) begin
                    if (req[d][u] && last_g[d] == u) begin
                        req[d][u] = 1'($urandom_range(0, 1));
                        tag[d][u] = W_TAG'($urandom); data[d][u] = $urandom; br[d][u] = 1'($urandom); tk[d][u] = 1'($urandom);
                    end else if (req[d][u]) begin
                        if ($urandom_range(0, 15) == 0) req[d][u] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        req[d][u] = 1'b1;
                        tag[d][u] = W_TAG'($urandom); data[d][u] = $urandom; br[d][u] = 1'($urandom); tk[d][u] = 1'($urandom);
                    end
                end
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        test_reset();
        test_single();
        test_rotation();
        test_starve();
        test_branch();
        test_reset_mid();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
